// File: rtl/tx_interp_commutator.sv
// tx_interp_commutator
// Buffers polyphase comb branch sets {E0..E3} in a two-entry FIFO and
// serialises them as one interpolated output stream, phase 0..3 per set.
// Each branch value is rounded, arithmetically shifted right by SHIFT and
// reduced to OUT_W bits.
// Build option: define INTERP_SAT_EN to clamp the reduced value and enable
// the sticky sat_flag. When it is undefined the value wraps and sat_flag
// stays 0.

module tx_interp_commutator #(
    parameter int OUT_W = 12,
    parameter int SHIFT = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [19:0]      in_e0,
    input  logic signed [19:0]      in_e1,
    input  logic signed [19:0]      in_e2,
    input  logic signed [19:0]      in_e3,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_data,
    output logic [1:0]              out_phase,
    output logic                    sat_flag,
    input  logic                    clr_flag
);

    // state   | meaning
    // S_EMPTY | no branch set buffered, out_valid low
    // S_ONE   | one set buffered, can still accept another
    // S_FULL  | both entries used, in_ready low

    localparam int IN_W  = 20;
    localparam int ACC_W = 21;
    localparam int ENT_W = 4 * IN_W;

    // Rounding constant: half an LSB of the shifted result.
    localparam logic signed [ACC_W-1:0] RND = ACC_W'(1) << (SHIFT - 1);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } occ_t;

    occ_t state_q;
    occ_t state_d;
    logic in_ready_q;
    logic in_ready_d;

    logic push;
    logic out_xfer;
    logic pop;

    logic [ENT_W-1:0] ent0_q;
    logic [ENT_W-1:0] ent1_q;
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       phase_q;

    logic [ENT_W-1:0]        head;
    logic signed [IN_W-1:0]  branch;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] scaled;
    logic signed [OUT_W-1:0] reduced;
    logic                    sat_hit;

    // in_ready comes from a register, so pushes never depend on out_ready.
    assign push     = in_valid & in_ready_q;
    assign out_xfer = out_valid & out_ready;
    assign pop      = out_xfer & (phase_q == 2'd3);
    assign in_ready = in_ready_q;

    // Occupancy state and registered in_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_EMPTY;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
        end
    end

    // Occupancy transitions from push/pop; FULL never sees a push.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_EMPTY: begin
                if (push) state_d = S_ONE;
            end
            S_ONE: begin
                if (push && !pop)      state_d = S_FULL;
                else if (!push && pop) state_d = S_EMPTY;
            end
            S_FULL: begin
                if (pop) state_d = S_ONE;
            end
            default: state_d = S_EMPTY;
        endcase
    end

    // FSM outputs: out_valid from the current occupancy, in_ready for next cycle.
    always_comb begin
        out_valid  = 1'b0;
        in_ready_d = 1'b1;
        case (state_q)
            S_EMPTY: out_valid = 1'b0;
            S_ONE:   out_valid = 1'b1;
            S_FULL:  out_valid = 1'b1;
            default: out_valid = 1'b0;
        endcase
        if (state_d == S_FULL) in_ready_d = 1'b0;
    end

    // Two-entry branch-set storage with ping-pong pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent0_q   <= '0;
            ent1_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            if (push) begin
                if (wr_ptr_q) ent1_q <= {in_e3, in_e2, in_e1, in_e0};
                else          ent0_q <= {in_e3, in_e2, in_e1, in_e0};
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
        end
    end

    // Output phase advances per transfer and wraps to 0 with the pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) phase_q <= 2'd0;
        else if (out_xfer) phase_q <= phase_q + 2'd1;
    end

    assign head = rd_ptr_q ? ent1_q : ent0_q;

    // Select the head entry's branch for the current phase.
    always_comb begin
        branch = '0;
        case (phase_q)
            2'd0: branch = head[0*IN_W +: IN_W];
            2'd1: branch = head[1*IN_W +: IN_W];
            2'd2: branch = head[2*IN_W +: IN_W];
            2'd3: branch = head[3*IN_W +: IN_W];
            default: branch = '0;
        endcase
    end

    // One guard bit is enough: |x| + 2^(SHIFT-1) stays inside 21 bits signed.
    assign acc    = {branch[IN_W-1], branch} + RND;
    assign scaled = acc >>> SHIFT;

`ifdef INTERP_SAT_EN
    localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] OUT_MIN = ~OUT_MAX;

    logic sat_q;

    // Clamp to the OUT_W signed range and flag when clamping was needed.
    always_comb begin
        sat_hit = 1'b0;
        reduced = OUT_W'(scaled);
        if (scaled > OUT_MAX) begin
            sat_hit = 1'b1;
            reduced = OUT_W'(OUT_MAX);
        end else if (scaled < OUT_MIN) begin
            sat_hit = 1'b1;
            reduced = OUT_W'(OUT_MIN);
        end
    end

    // Sticky saturation flag; a new saturating transfer wins over clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sat_q <= 1'b0;
        else if (out_xfer && sat_hit) sat_q <= 1'b1;
        else if (clr_flag) sat_q <= 1'b0;
    end

    assign sat_flag = sat_q;
`else
    logic unused_sat;

    // Wrap: keep the low OUT_W bits of the scaled value.
    always_comb begin
        sat_hit = 1'b0;
        reduced = OUT_W'(scaled);
    end

    assign sat_flag   = 1'b0;
    assign unused_sat = clr_flag | sat_hit;
`endif

    // Outputs read as zero whenever nothing is buffered.
    always_comb begin
        out_data  = '0;
        out_phase = 2'd0;
        if (out_valid) begin
            out_data  = reduced;
            out_phase = phase_q;
        end
    end

endmodule

// File: tb/tb_tx_interp_commutator.sv
// Directed bench for tx_interp_commutator (OUT_W=12, SHIFT=8). Expected
// values are hand-computed; the saturating vector depends on INTERP_SAT_EN.

module tb_tx_interp_commutator;

`ifdef INTERP_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic signed [19:0] in_e0, in_e1, in_e2, in_e3;
    logic               out_valid;
    logic               out_ready;
    logic signed [11:0] out_data;
    logic [1:0]         out_phase;
    logic               sat_flag;
    logic               clr_flag;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [3:0][19:0] e;
        logic [3:0][11:0] d;
        logic             s;
    } vec_t;

    localparam int NV = 5;
    vec_t vecs [NV];

    tx_interp_commutator #(.OUT_W(12), .SHIFT(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_e0     (in_e0),
        .in_e1     (in_e1),
        .in_e2     (in_e2),
        .in_e3     (in_e3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_phase (out_phase),
        .sat_flag  (sat_flag),
        .clr_flag  (clr_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setv(input int i, input int a0, input int a1, input int a2, input int a3,
                        input int b0, input int b1, input int b2, input int b3, input bit s);
        vecs[i].e[0] = 20'(a0); vecs[i].e[1] = 20'(a1);
        vecs[i].e[2] = 20'(a2); vecs[i].e[3] = 20'(a3);
        vecs[i].d[0] = 12'(b0); vecs[i].d[1] = 12'(b1);
        vecs[i].d[2] = 12'(b2); vecs[i].d[3] = 12'(b3);
        vecs[i].s    = s;
    endtask

    function automatic int expd(input int i, input int p);
        logic [11:0] raw;
        raw = vecs[i].d[p];
        return int'($signed(raw));
    endfunction

    task automatic drive(input int i);
        in_e0 = vecs[i].e[0];
        in_e1 = vecs[i].e[1];
        in_e2 = vecs[i].e[2];
        in_e3 = vecs[i].e[3];
    endtask

    // Push one set into an empty block and drain it with out_ready held high.
    task automatic run_vec(input int v, input string tag);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        drive(v);
        chk({tag, "_in_ready"}, int'(in_ready), 1);
        step();
        in_valid = 1'b0;
        for (int p = 0; p < 4; p++) begin
            chk({tag, "_valid"}, int'(out_valid), 1);
            chk({tag, "_data"}, int'(out_data), expd(v, p));
            chk({tag, "_phase"}, int'(out_phase), p);
            step();
        end
        chk({tag, "_drained"}, int'(out_valid), 0);
    endtask

    initial begin
        int nxt, k, bubbles;
        bit accepted;

        setv(0, 256, 384, -384, 0, 1, 2, -1, 0, 1'b0);
        setv(1, 0, 127, 128, -128, 0, 0, 1, 0, 1'b0);
        setv(2, -129, -385, 1000, -1000, -1, -2, 4, -4, 1'b0);
        setv(3, 524287, -524288, 524031, -524160, SAT ? 2047 : -2048, -2048, 2047, -2047, SAT);
        setv(4, 524032, -1, 255, -256, 2047, 0, 1, -1, SAT);

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        clr_flag  = 1'b0;
        drive(0);

        // Reset state
        step();
        step();
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_phase", int'(out_phase), 0);
        chk("rst_sat_flag", int'(sat_flag), 0);
        rst_n = 1'b1;
        chk("rel_in_ready_before_edge", int'(in_ready), 0);
        step();
        chk("rel_in_ready_after_edge", int'(in_ready), 1);

        // Table: one set each, drained at full rate; sat_flag is sticky
        for (int v = 0; v < NV; v++) begin
            run_vec(v, "tbl");
            chk("tbl_sat_flag", int'(sat_flag), int'(vecs[v].s));
        end

        // Clear alone
        clr_flag = 1'b1;
        step();
        clr_flag = 1'b0;
        chk("clr_alone", int'(sat_flag), 0);

        // Back-to-back sets with out_ready high: no bubbles
        nxt = 0; k = 0; bubbles = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 40 && k < 12; c++) begin
            if (nxt < 3) begin
                in_valid = 1'b1;
                drive(nxt);
            end else begin
                in_valid = 1'b0;
            end
            accepted = in_valid && in_ready;
            if (out_valid) begin
                chk("stream_data", int'(out_data), expd(k / 4, k % 4));
                chk("stream_phase", int'(out_phase), k % 4);
                k++;
            end else if (k > 0) begin
                bubbles++;
            end
            step();
            if (accepted) nxt++;
        end
        in_valid = 1'b0;
        chk("stream_count", k, 12);
        chk("stream_bubbles", bubbles, 0);
        chk("stream_accepted", nxt, 3);

        // Backpressure: two accepted, third refused until the phase-3 pop
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(0);
        chk("bp_accept_a", int'(in_ready), 1);
        step();
        drive(1);
        chk("bp_accept_b", int'(in_ready), 1);
        step();
        drive(2);
        for (int i = 0; i < 3; i++) begin
            chk("bp_full_in_ready", int'(in_ready), 0);
            chk("bp_hold_data", int'(out_data), expd(0, 0));
            chk("bp_hold_phase", int'(out_phase), 0);
            step();
        end
        for (int p = 0; p < 4; p++) begin
            chk("bp_pulse_data", int'(out_data), expd(0, p));
            chk("bp_pulse_in_ready", int'(in_ready), 0);
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            if (p < 3) step();
        end
        chk("bp_after_pop_in_ready", int'(in_ready), 1);
        chk("bp_after_pop_data", int'(out_data), expd(1, 0));
        chk("bp_after_pop_phase", int'(out_phase), 0);
        step();
        in_valid = 1'b0;
        chk("bp_c_taken_full", int'(in_ready), 0);
        out_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            chk("bp_drain_valid", int'(out_valid), 1);
            chk("bp_drain_data", int'(out_data), expd(1 + j / 4, j % 4));
            step();
        end
        chk("bp_drain_empty", int'(out_valid), 0);

        // Saturating transfer coinciding with clear keeps the flag
        run_vec(3, "sat1");
        chk("sat1_flag", int'(sat_flag), int'(SAT));
        in_valid = 1'b1;
        drive(3);
        step();
        in_valid = 1'b0;
        clr_flag = 1'b1;
        step();
        clr_flag = 1'b0;
        chk("sat_clr_same_cycle", int'(sat_flag), int'(SAT));
        step(); step(); step();
        chk("sat2_empty", int'(out_valid), 0);
        clr_flag = 1'b1;
        step();
        clr_flag = 1'b0;
        chk("sat_clr_alone", int'(sat_flag), 0);

        // Reset mid-frame with the FIFO full at phase 2
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(0);
        step();
        drive(1);
        step();
        in_valid = 1'b0;
        chk("mr_full", int'(in_ready), 0);
        out_ready = 1'b1;
        step();
        step();
        out_ready = 1'b0;
        chk("mr_phase2", int'(out_phase), 2);
        chk("mr_data2", int'(out_data), expd(0, 2));
        rst_n = 1'b0;
        #1;
        chk("mr_out_valid", int'(out_valid), 0);
        chk("mr_out_data", int'(out_data), 0);
        chk("mr_out_phase", int'(out_phase), 0);
        chk("mr_in_ready", int'(in_ready), 0);
        chk("mr_sat_flag", int'(sat_flag), 0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("mr_rel_in_ready", int'(in_ready), 1);
        chk("mr_discarded", int'(out_valid), 0);
        run_vec(2, "mr_new");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case a sequence stalls.
    initial begin
        #20000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/tx_interp_commutator.md
TX_INTERP_COMMUTATOR -- requirements
Module: tx_interp_commutator

Interface
REQ-001 Parameter OUT_W, default 12: width of the serialized output sample.
REQ-002 Parameter SHIFT, default 8: arithmetic right-shift applied to each polyphase branch result, with rounding.
REQ-003 clk  in  1  clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 in_valid  in  1  the four branch outputs in_e0..in_e3 are valid this cycle.
REQ-006 in_ready  out  1  block can accept a branch set this cycle.
REQ-007 in_e0, in_e1, in_e2, in_e3  in  20 each, signed  polyphase comb branch outputs E0..E3.
REQ-008 out_valid  out  1  out_data holds a valid interpolated sample.
REQ-009 out_ready  in  1  downstream accepts out_data this cycle.
REQ-010 out_data  out  OUT_W, signed  interpolated sample, rounded and scaled.
REQ-011 out_phase  out  2  index (0..3) of the branch currently on out_data.
REQ-012 sat_flag  out  1  sticky flag: a saturation occurred.
REQ-013 clr_flag  in  1  synchronous clear of sat_flag.

Function
REQ-014 Input transfer = in_valid & in_ready; output transfer = out_valid & out_ready.
REQ-015 The buffer is a two-entry FIFO, each entry holding {E0,E1,E2,E3}; occupancy state EMPTY(0) / ONE(1) / FULL(2).
REQ-016 in_ready = 1 in EMPTY and ONE, 0 in FULL; it is a registered function of occupancy only (no combinational path from out_ready).
REQ-017 In FULL with an output pop in the same cycle, no push is accepted that cycle; the state becomes ONE and in_ready rises next cycle.
REQ-018 Transitions: push only -> occupancy+1; pop only -> occupancy-1; push and pop in ONE -> remains ONE.
REQ-019 out_valid = 1 whenever occupancy > 0; first out_valid asserts the cycle after the input transfer into EMPTY (latency 1).
REQ-020 out_phase starts at 0; each output transfer increments it; a transfer at phase 3 pops the head entry and returns out_phase to 0.
REQ-021 out_data = scale(head.E[out_phase]); out_data and out_phase stay stable while out_valid=1 and out_ready=0.
REQ-022 scale(x) = (x + 2^(SHIFT-1)) >>> SHIFT, computed at 21 bits with no intermediate overflow, then reduced to OUT_W per REQ-027/028.
REQ-023 Sustained throughput: one branch set per 4 output transfers; with out_ready held at 1 there are no bubbles while input is supplied back to back.
REQ-024 When out_valid=0, out_data = 0 and out_phase = 0.
REQ-025 sat_flag sets on any output transfer whose value saturated; clr_flag clears it; a simultaneous set and clear leaves it set.

Reset
REQ-026 While rst_n=0: occupancy EMPTY, both FIFO entries zero, out_phase=0, out_valid=0, out_data=0, in_ready=0, sat_flag=0; in_ready goes to 1 on the first clock edge after reset release; a reset mid-frame discards all buffered samples.

Configuration
REQ-027 With INTERP_SAT_EN defined: the scaled value is clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1], and sat_flag operates per REQ-025.
REQ-028 Without INTERP_SAT_EN: the scaled value wraps by keeping its low OUT_W bits, and sat_flag is constant 0.

Verification (OUT_W=12, SHIFT=8)
REQ-029 Push {256,384,-384,0} with out_ready=1 -> out_data 1,2,-1,0 on consecutive cycles, with out_phase 0,1,2,3.
REQ-030 Push E3=524287 with INTERP_SAT_EN -> out_data=2047 and sat_flag=1; without the macro -> out_data=-2048 and sat_flag=0.
REQ-031 out_ready=0, three sets offered back to back -> first two accepted, in_ready=0 from the cycle after the second accept, out_data held constant.
REQ-032 FULL state, out_ready pulses until the phase-3 pop -> in_ready=1 the next cycle, and the third set is accepted with no data loss or reordering.
REQ-033 rst_n asserted at out_phase=2 with the FIFO FULL -> all outputs reach reset values immediately; after release, a new set emerges starting at phase 0.
REQ-034 sat_flag=1, then clr_flag=1 in the same cycle as a new saturating transfer -> sat_flag remains 1; clr_flag alone -> sat_flag=0 the next cycle.
